mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 40 ++++
 rtl/mem_access_unit_load_ext.sv | 33 +++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for mem_access_unit: op encodings, FSM states and
// request-classification helpers.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Low address bits that are legal for the access size; ANDing with this
  // mask forces an offending offset back to natural alignment.
  function automatic logic [1:0] lo_mask(op_e op);
    case (op)
      OP_LW, OP_SW:         return 2'b00;
      OP_LH, OP_LHU, OP_SH: return 2'b10;
      default:              return 2'b11;
    endcase
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] lo);
    return (lo & ~lo_mask(op)) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: selects the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it to 32 bits according to the load op.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data_out
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (byte_off)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      OP_LB:   data_out = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data_out = {24'h0, lane_b};
      OP_LH:   data_out = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data_out = {16'h0, lane_h};
      default: data_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit with lane steering,
// load extension and ack timeout. Optional macro: MAU_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  op_e         req_op_e;
  logic [1:0]  eff_off;
  logic [31:0] load_data;

  assign req_op_e = op_e'(req_op);
  assign eff_off  = req_addr[1:0] & lo_mask(req_op_e);

`ifdef MAU_MISALIGN_TRAP_EN
  logic req_misaligned;
  assign req_misaligned = is_misaligned(req_op_e, req_addr[1:0]);
`endif

  load_ext u_load_ext (
    .op       (op_q),
    .byte_off (off_q),
    .rdata    (mem_rdata),
    .data_out (load_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    resp_rdata_d = resp_rdata_q;
    addr_err_d   = addr_err_q;
    bus_err_d    = bus_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op_e;
          off_d      = eff_off;
          addr_d     = {req_addr[31:2], 2'b00};
          we_d       = is_store(req_op_e);
          wait_cnt_d = '0;
          case (req_op_e)
            OP_SB: begin
              be_d    = 4'b0001 << eff_off;
              wdata_d = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
              be_d    = eff_off[1] ? 4'b1100 : 4'b0011;
              wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
              be_d    = '1;
              wdata_d = req_wdata;
            end
          endcase
          state_d = ST_ACCESS;
`ifdef MAU_MISALIGN_TRAP_EN
          if (req_misaligned) begin
            state_d      = ST_DONE;
            resp_rdata_d = '0;
            addr_err_d   = 1'b1;
            bus_err_d    = 1'b0;
          end
`endif
        end
      end
      ST_ACCESS: begin
        // Ack is tested before the timeout so an ack on the last allowed cycle wins.
        if (mem_ack) begin
          state_d      = ST_DONE;
          resp_rdata_d = we_q ? '0 : load_data;
          addr_err_d   = 1'b0;
          bus_err_d    = 1'b0;
        end else if (wait_cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
          state_d      = ST_DONE;
          resp_rdata_d = '0;
          addr_err_d   = 1'b0;
          bus_err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LW;
      off_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      resp_rdata_q <= '0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_rdata_q <= resp_rdata_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign mem_en     = (state_q == ST_ACCESS);
  assign mem_we     = mem_en & we_q;
  assign mem_be     = mem_en ? be_q : '0;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;

endmodule
